mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 104 ++++++++++
 tb/tb_mem_port_arbiter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Two-requester memory port bundle plus the single-port RAM side.
// The slave modport is the arbiter's view; the master modport is the requester/RAM environment.
interface mem_port_arbiter_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 8
);
    logic                  p0_req_valid;
    logic                  p0_req_ready;
    logic [AWIDTH-1:0]     p0_req_addr;
    logic [DWIDTH-1:0]     p0_req_wdata;
    logic [DWIDTH/8-1:0]   p0_req_wstrb;
    logic                  p0_resp_valid;
    logic                  p0_resp_ready;
    logic [DWIDTH-1:0]     p0_resp_rdata;

    logic                  p1_req_valid;
    logic                  p1_req_ready;
    logic [AWIDTH-1:0]     p1_req_addr;
    logic [DWIDTH-1:0]     p1_req_wdata;
    logic [DWIDTH/8-1:0]   p1_req_wstrb;
    logic                  p1_resp_valid;
    logic                  p1_resp_ready;
    logic [DWIDTH-1:0]     p1_resp_rdata;

    logic                  mem_en;
    logic [DWIDTH/8-1:0]   mem_wbe;
    logic [AWIDTH-1:0]     mem_addr;
    logic [DWIDTH-1:0]     mem_d;
    logic [DWIDTH-1:0]     mem_q;

    modport slave (
        input  p0_req_valid, p0_req_addr, p0_req_wdata, p0_req_wstrb, p0_resp_ready,
        output p0_req_ready, p0_resp_valid, p0_resp_rdata,
        input  p1_req_valid, p1_req_addr, p1_req_wdata, p1_req_wstrb, p1_resp_ready,
        output p1_req_ready, p1_resp_valid, p1_resp_rdata,
        output mem_en, mem_wbe, mem_addr, mem_d,
        input  mem_q
    );

    modport master (
        output p0_req_valid, p0_req_addr, p0_req_wdata, p0_req_wstrb, p0_resp_ready,
        input  p0_req_ready, p0_resp_valid, p0_resp_rdata,
        output p1_req_valid, p1_req_addr, p1_req_wdata, p1_req_wstrb, p1_resp_ready,
        input  p1_req_ready, p1_resp_valid, p1_resp_rdata,
        input  mem_en, mem_wbe, mem_addr, mem_d,
        output mem_q
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one sync-read RAM between two ports; response one cycle after accept.
// One transaction outstanding; a stalled response blocks new accepts until its handshake.
module mem_port_arbiter #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus
);
    localparam int BWIDTH = DWIDTH / 8;

    typedef enum logic {ST_IDLE, ST_RESP} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_owner;
    logic                r_last_grant;

    logic                w_owner_resp_rdy;
    logic                w_can_accept;
    logic                w_p0_wins;
    logic                w_p1_wins;
    logic                w_p0_acc;
    logic                w_p1_acc;
    logic                w_accept;
    logic                w_winner;
    logic [AWIDTH-1:0]   w_req_addr;
    logic [DWIDTH-1:0]   w_req_wdata;
    logic [BWIDTH-1:0]   w_req_wstrb;

    assign w_owner_resp_rdy = r_owner ? bus.p1_resp_ready : bus.p0_resp_ready;
    assign w_can_accept     = (r_state == ST_IDLE) || w_owner_resp_rdy;

    // A port "would win" from the other port's valid only, so ready never depends on its own valid.
    assign w_p0_wins = !bus.p1_req_valid || r_last_grant;
    assign w_p1_wins = !bus.p0_req_valid || !r_last_grant;

    assign bus.p0_req_ready = w_can_accept && w_p0_wins;
    assign bus.p1_req_ready = w_can_accept && w_p1_wins;

    // Readies stay live in reset, but nothing may reach the RAM until release.
    assign w_p0_acc = rst_n && bus.p0_req_valid && bus.p0_req_ready;
    assign w_p1_acc = rst_n && bus.p1_req_valid && bus.p1_req_ready;
    assign w_accept = w_p0_acc || w_p1_acc;
    assign w_winner = w_p1_acc;

    assign w_req_addr  = w_winner ? bus.p1_req_addr  : bus.p0_req_addr;
    assign w_req_wdata = w_winner ? bus.p1_req_wdata : bus.p0_req_wdata;
    assign w_req_wstrb = w_winner ? bus.p1_req_wstrb : bus.p0_req_wstrb;

    assign bus.p0_resp_rdata = bus.mem_q;
    assign bus.p1_resp_rdata = bus.mem_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_owner      <= w_winner;
                r_last_grant <= w_winner;
            end
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        bus.p0_resp_valid = 1'b0;
        bus.p1_resp_valid = 1'b0;
        bus.mem_en        = 1'b0;
        bus.mem_wbe       = '0;
        bus.mem_addr      = w_req_addr;
        bus.mem_d         = w_req_wdata;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                bus.p0_resp_valid = !r_owner;
                bus.p1_resp_valid = r_owner;
                // Accept here implies the owner's handshake, so back-to-back stays in RESP.
                if (w_accept) begin
                    w_state_nxt = ST_RESP;
                end else if (w_owner_resp_rdy) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_accept) begin
            bus.mem_en  = 1'b1;
            bus.mem_wbe = w_req_wstrb;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: behavioural RAM, round-robin reference model and response scoreboard.
module tb_mem_port_arbiter;
    logic clk;
    logic rst_n;

    mem_port_arbiter_if #(.DWIDTH(32), .AWIDTH(8)) bus ();

    mem_port_arbiter #(.DWIDTH(32), .AWIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Environment RAM: single port, synchronous read, byte write enables, q held while idle.
    logic [31:0] ram [256];
    logic [31:0] ram_q;
    assign bus.mem_q = ram_q;
    always @(posedge clk) begin
        if (bus.mem_en) begin
            ram_q <= ram[bus.mem_addr];
            for (int b = 0; b < 4; b++)
                if (bus.mem_wbe[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_d[8*b +: 8];
        end
    end

    int errors = 0;
    int checks = 0;

    // Reference model: word array, one-outstanding flag, owner and round-robin pointer.
    logic [31:0] m_mem [256];
    logic        m_busy, m_owner, m_last;
    logic        m_acc0, m_acc1;
    logic        d_win, d_en;
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    logic        hold [2];
    logic [31:0] hdat [2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (strb[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 1'b0;
        m_last  = 1'b1;
        q0.delete();
        q1.delete();
    endtask

    task automatic check_cycle();
        logic        can, w0, w1, a0, a1;
        logic [7:0]  addr;
        logic [31:0] d, old;
        logic [3:0]  strb;
        can = !m_busy || (m_owner ? bus.p1_resp_ready : bus.p0_resp_ready);
        w0  = !bus.p1_req_valid || m_last;
        w1  = !bus.p0_req_valid || !m_last;
        chk("p0_req_ready", bus.p0_req_ready, can && w0);
        chk("p1_req_ready", bus.p1_req_ready, can && w1);
        chk("p0_resp_valid", bus.p0_resp_valid, m_busy && !m_owner);
        chk("p1_resp_valid", bus.p1_resp_valid, m_busy && m_owner);
        a0 = rst_n && bus.p0_req_valid && can && w0;
        a1 = rst_n && bus.p1_req_valid && can && w1;
        m_acc0 = a0;
        m_acc1 = a1;
        d_win  = bus.p1_req_valid && bus.p1_req_ready;
        d_en   = bus.mem_en;
        chk("mem_en", bus.mem_en, a0 || a1);
        if (a0 || a1) begin
            addr = a1 ? bus.p1_req_addr  : bus.p0_req_addr;
            d    = a1 ? bus.p1_req_wdata : bus.p0_req_wdata;
            strb = a1 ? bus.p1_req_wstrb : bus.p0_req_wstrb;
            chk("mem_addr", bus.mem_addr, addr);
            chk("mem_d", bus.mem_d, d);
            chk("mem_wbe", bus.mem_wbe, strb);
            old = m_mem[addr];
            m_mem[addr] = merge(old, d, strb);
            if (a1) q1.push_back(old);
            else    q0.push_back(old);
            m_owner = a1;
            m_last  = a1;
            m_busy  = 1'b1;
        end else begin
            chk("mem_wbe_idle", bus.mem_wbe, 4'b0000);
            if (m_busy && can) m_busy = 1'b0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mon_port(input int n, input logic vld, input logic rdy, input logic [31:0] dat);
        logic [31:0] e;
        if (hold[n]) begin
            chk(n ? "p1_hold_valid" : "p0_hold_valid", vld, 1'b1);
            chk(n ? "p1_hold_rdata" : "p0_hold_rdata", dat, hdat[n]);
        end
        hold[n] = vld && !rdy;
        hdat[n] = dat;
        if (vld && rdy) begin
            if ((n == 0 && q0.size() == 0) || (n == 1 && q1.size() == 0)) begin
                checks++;
                errors++;
                $display("FAIL p%0d_unexpected_resp: got rdata %0h expected no response", n, dat);
            end else begin
                e = n ? q1.pop_front() : q0.pop_front();
                chk(n ? "p1_rdata" : "p0_rdata", dat, e);
            end
        end
    endtask

    // Monitor: decoupled from stimulus, pops one expectation per response handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold[0] = 1'b0;
            hold[1] = 1'b0;
        end else begin
            mon_port(0, bus.p0_resp_valid, bus.p0_resp_ready, bus.p0_resp_rdata);
            mon_port(1, bus.p1_resp_valid, bus.p1_resp_ready, bus.p1_resp_rdata);
        end
    end

    task automatic set_req(input int n, input logic v, input logic [7:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        if (n == 0) begin
            bus.p0_req_valid = v; bus.p0_req_addr = a; bus.p0_req_wdata = d; bus.p0_req_wstrb = s;
        end else begin
            bus.p1_req_valid = v; bus.p1_req_addr = a; bus.p1_req_wdata = d; bus.p1_req_wstrb = s;
        end
    endtask

    initial begin
        logic [31:0] v;
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            ram[i]   = v;
            m_mem[i] = v;
        end
        ram[16] = 32'hDEADBEEF; m_mem[16] = 32'hDEADBEEF;
        ram[5]  = 32'hAABBCCDD; m_mem[5]  = 32'hAABBCCDD;
        ram_q = '0;
        hold[0] = 1'b0; hold[1] = 1'b0;
        hdat[0] = '0;   hdat[1] = '0;
        rst_n = 1'b0;
        model_reset();
        set_req(0, 1'b0, 8'h0, 32'h0, 4'h0);
        set_req(1, 1'b0, 8'h0, 32'h0, 4'h0);
        bus.p0_resp_ready = 1'b1;
        bus.p1_resp_ready = 1'b1;

        // Reset state with both ports requesting.
        @(posedge clk); @(posedge clk); #1;
        set_req(0, 1'b1, 8'h01, 32'h0, 4'h0);
        set_req(1, 1'b1, 8'h02, 32'h12345678, 4'hF);
        #1;
        chk("rst_p0_req_ready", bus.p0_req_ready, 1'b1);
        chk("rst_p1_req_ready", bus.p1_req_ready, 1'b0);
        chk("rst_mem_en", bus.mem_en, 1'b0);
        chk("rst_mem_wbe", bus.mem_wbe, 4'b0000);
        chk("rst_p0_resp_valid", bus.p0_resp_valid, 1'b0);
        chk("rst_p1_resp_valid", bus.p1_resp_valid, 1'b0);
        set_req(0, 1'b0, 8'h0, 32'h0, 4'h0);
        set_req(1, 1'b0, 8'h0, 32'h0, 4'h0);
        rst_n = 1'b1;
        step();

        // Single read.
        set_req(0, 1'b1, 8'h10, 32'h0, 4'h0);
        #1;
        chk("rd_p0_req_ready", bus.p0_req_ready, 1'b1);
        chk("rd_mem_en", bus.mem_en, 1'b1);
        step();
        set_req(0, 1'b0, 8'h0, 32'h0, 4'h0);
        chk("rd_resp_valid", bus.p0_resp_valid, 1'b1);
        chk("rd_resp_rdata", bus.p0_resp_rdata, 32'hDEADBEEF);
        step();

        // Partial byte write then readback.
        set_req(1, 1'b1, 8'h05, 32'h11223344, 4'b0011);
        #1;
        chk("wr_mem_wbe", bus.mem_wbe, 4'b0011);
        step();
        set_req(1, 1'b0, 8'h0, 32'h0, 4'h0);
        chk("wr_resp_old", bus.p1_resp_rdata, 32'hAABBCCDD);
        step();
        set_req(1, 1'b1, 8'h05, 32'h0, 4'h0);
        step();
        set_req(1, 1'b0, 8'h0, 32'h0, 4'h0);
        chk("wr_readback", bus.p1_resp_rdata, 32'hAABB3344);
        step();

        // Backpressure: p0 response stalled five cycles while p1 waits.
        bus.p0_resp_ready = 1'b0;
        set_req(0, 1'b1, 8'h10, 32'h0, 4'h0);
        step();
        set_req(0, 1'b0, 8'h0, 32'h0, 4'h0);
        set_req(1, 1'b1, 8'h05, 32'h0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_p1_req_ready", bus.p1_req_ready, 1'b0);
            chk("bp_p0_rdata", bus.p0_resp_rdata, 32'hDEADBEEF);
            step();
        end
        bus.p0_resp_ready = 1'b1;
        #1;
        chk("bp_release_p1_ready", bus.p1_req_ready, 1'b1);
        step();
        set_req(1, 1'b0, 8'h0, 32'h0, 4'h0);
        step();

        // Reset while a response is pending.
        bus.p0_resp_ready = 1'b0;
        set_req(0, 1'b1, 8'h10, 32'h0, 4'h0);
        step();
        set_req(0, 1'b0, 8'h0, 32'h0, 4'h0);
        chk("mid_resp_valid_before", bus.p0_resp_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_resp_valid_async", bus.p0_resp_valid, 1'b0);
        chk("mid_mem_en", bus.mem_en, 1'b0);
        model_reset();
        step();
        rst_n = 1'b1;
        bus.p0_resp_ready = 1'b1;
        bus.p1_resp_ready = 1'b1;
        set_req(0, 1'b1, 8'h03, 32'h0, 4'h0);
        set_req(1, 1'b1, 8'h04, 32'h0, 4'h0);
        #1;
        chk("post_rst_p0_ready", bus.p0_req_ready, 1'b1);
        chk("post_rst_p1_ready", bus.p1_req_ready, 1'b0);

        // Continuous contention: strict alternation starting with p0, RAM busy every cycle.
        for (int i = 0; i < 6; i++) begin
            step();
            chk("contend_grant", d_win, i % 2);
            chk("contend_mem_en", d_en, 1'b1);
        end
        set_req(0, 1'b0, 8'h0, 32'h0, 4'h0);
        set_req(1, 1'b0, 8'h0, 32'h0, 4'h0);
        step();
        step();

        // Random traffic; a request is held until accepted.
        m_acc0 = 1'b0;
        m_acc1 = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!bus.p0_req_valid || m_acc0)
                set_req(0, $urandom_range(0, 3) != 0, 8'($urandom_range(0, 15)), $urandom,
                        ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0);
            if (!bus.p1_req_valid || m_acc1)
                set_req(1, $urandom_range(0, 3) != 0, 8'($urandom_range(0, 15)), $urandom,
                        ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0);
            bus.p0_resp_ready = $urandom_range(0, 3) != 0;
            bus.p1_resp_ready = $urandom_range(0, 3) != 0;
            step();
        end
        set_req(0, 1'b0, 8'h0, 32'h0, 4'h0);
        set_req(1, 1'b0, 8'h0, 32'h0, 4'h0);
        bus.p0_resp_ready = 1'b1;
        bus.p1_resp_ready = 1'b1;
        step();
        step();
        step();
        chk("p0_pending_at_end", q0.size(), 0);
        chk("p1_pending_at_end", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
